step_dir_out: RTL and testbench
===============================

# step_dir_out

Parametrised step/dir output stage for N motion axes that sits between the per-axis profile generators and the driver pins. It buffers step strobes, each tagged with a direction, in a per-axis FIFO. It then re-times them onto step/dir pins with a programmable direction-setup time, minimum pulse width and minimum gap. It also keeps a signed position counter per axis that the executor can read back.

## Interface
Parameters:
- AXES, 4, number of axes
- PW_W, 16, width of timing registers
- DEPTH_W, 3, log2 of per-axis FIFO depth (depth 8)
- POS_W, 32, position counter width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- enable  in  1  high: FIFOs may be popped; low: in-flight pulse completes, nothing new popped
- step_in  in  AXES  one-cycle step strobes
- dir_in  in  AXES  direction qualifying step_in (1 = positive)
- pulse_len  in  PW_W  step high time in cycles; 0 treated as 1
- gap_len  in  PW_W  minimum low time after a pulse in cycles; 0 treated as 1
- dir_setup  in  PW_W  cycles dir_out must be stable before step rises; 0 allowed
- invert_step  in  AXES  per-axis step polarity
- invert_dir  in  AXES  per-axis dir polarity
- pos_load  in  AXES  per-axis load strobe
- pos_val  in  AXES*POS_W  load values, axis i at [i*POS_W +: POS_W]
- ovf_clr  in  AXES  clears sticky overflow
- step_out  out  AXES  step pins
- dir_out  out  AXES  dir pins
- pos  out  AXES*POS_W  signed positions
- overflow  out  AXES  sticky, a strobe was dropped because the FIFO was full
- busy  out  AXES  FIFO non-empty or FSM not IDLE

## Operation
- Each axis is independent.
- FIFO: each step_in pushes the dir_in bit. When the FIFO is full, the push is dropped and overflow is set.
- A push and a pop in the same cycle leave the count unchanged; this also applies when the FIFO is full.
- ovf_clr and a new overflow in the same cycle: set wins.
- Each axis has an FSM with states IDLE, SETUP, HIGH and LOW. It holds an internal registered dir_q and step_q.
- IDLE:
  - If enable is high and the FIFO is non-empty, pop the FIFO.
  - If the popped dir equals dir_q, go to HIGH.
  - Otherwise load the popped dir into dir_q and go to SETUP. With dir_setup = 0, go to HIGH in the same cycle instead.
- SETUP: hold for dir_setup cycles, then go to HIGH.
- HIGH:
  - step_q = 1 for max(pulse_len, 1) cycles.
  - On entry, pos increments by 1 if dir_q = 1 and decrements by 1 otherwise, two's-complement wrap at POS_W.
  - After the hold, go to LOW.
- LOW: step_q = 0 for max(gap_len, 1) cycles, then go to IDLE.
- Timing inputs are captured into the phase counter on phase entry. Changes during a phase affect only later phases.
- enable low: an in-progress SETUP, HIGH or LOW runs to completion, the FSM parks in IDLE, and the FIFO continues to accept pushes.
- pos_load has priority over a same-cycle step update.
- Output polarity: step_out = step_q ^ invert_step; dir_out = dir_q ^ invert_dir. The XOR is applied after the register, so toggling an invert bit changes the pin immediately.
- Reset, asynchronous, all axes:
  - FIFO empty, FSM IDLE, dir_q = 0, step_q = 0
  - step_out = invert_step, dir_out = invert_dir
  - pos = 0, overflow = 0, busy = 0
- Reset asserted mid-pulse aborts the pulse immediately; pending steps are lost.

## Timing
- step_in high in cycle 0 is pushed at edge 1.
- Same direction: the FSM pops at edge 2 and step_q is high from cycle 2, giving 2-cycle latency.
- Direction change with dir_setup = D > 0: dir_q changes in cycle 2 and step_q rises in cycle 2+D.
- pos updates at the same edge where step_q rises.
- Back-to-back same-direction step period = pulse_len + gap_len + 1 cycles, including one IDLE cycle.
- busy goes high in cycle 1 after a push. It goes low the cycle after LOW completes when the FIFO is empty.
- overflow goes high the cycle after the dropped strobe.

## Structure
- Shared package step_pkg holds the FSM state enum (IDLE, SETUP, HIGH, LOW) and the default parameter constants.
- Sub-module step_axis_chan contains one axis: FIFO, FSM and position counter. step_dir_out instantiates AXES copies with a generate loop and handles the port slicing.

## Test plan
- Single step: pulse_len=3, gap_len=2, dir_in=1 at cycle 0 -> step_out high in cycles 2–4, pos 0→1 at edge 2, busy low from cycle 8.
- Direction reversal: steps dir 1 then dir 0 with dir_setup=5 -> dir_out falls at the start of the second pulse's SETUP, step_out rises exactly 5 cycles later, pos returns to 0.
- Overflow: 10 strobes on consecutive cycles, DEPTH_W=3, pulse_len=4 -> exactly 8 or 9 pulses emitted (9 if the FIFO popped one before filling), overflow[0]=1, ovf_clr clears it.
- Enable gating: 3 strobes queued, enable dropped during the first pulse -> that pulse completes, nothing more is emitted; re-enable -> the remaining 2 pulses are emitted.
- Position load: pos_load on the same edge as a pulse's rising edge with pos_val=100 -> pos = 100, not 101; a dir=0 step from 0 wraps to 0xFFFFFFFF.
- Async reset mid-pulse with invert_step=1 -> step_out returns to 1 immediately without waiting for a clock, FIFO empty, pos = 0.

Source files
------------

// File: rtl/step_pkg.sv
// Shared constants for the step/dir output stage: default parameters and FSM state codes.
package step_pkg;

  localparam int unsigned AXES_DEF    = 4;
  localparam int unsigned PW_W_DEF    = 16;
  localparam int unsigned DEPTH_W_DEF = 3;
  localparam int unsigned POS_W_DEF   = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;
  localparam logic [1:0] ST_LOW   = 2'd3;

endpackage

// File: rtl/step_axis_chan.sv
// One axis: direction FIFO, step pulse re-timing FSM and signed position counter.
module step_axis_chan
  import step_pkg::*;
#(
  parameter int unsigned PW_W    = PW_W_DEF,
  parameter int unsigned DEPTH_W = DEPTH_W_DEF,
  parameter int unsigned POS_W   = POS_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             step_in,
  input  logic             dir_in,
  input  logic [PW_W-1:0]  pulse_len,
  input  logic [PW_W-1:0]  gap_len,
  input  logic [PW_W-1:0]  dir_setup,
  input  logic             invert_step,
  input  logic             invert_dir,
  input  logic             pos_load,
  input  logic [POS_W-1:0] pos_val,
  input  logic             ovf_clr,
  output logic             step_out,
  output logic             dir_out,
  output logic [POS_W-1:0] pos,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned DEPTH = 1 << DEPTH_W;

  logic [1:0]         state, state_nxt;
  logic [PW_W-1:0]    cnt, cnt_nxt;
  logic               dir_q, dir_nxt;
  logic               step_q, step_nxt;
  logic [DEPTH-1:0]   fifo_mem;
  logic [DEPTH_W-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_W:0]   count, count_nxt;
  logic               pop_c, rise_c, full_c, push_c, drop_c, rd_dir_c;
  logic [PW_W-1:0]    pulse_ld_c, gap_ld_c;

  // Zero-length pulse/gap settings are promoted to one cycle.
  always_comb begin
    pulse_ld_c = (pulse_len == '0) ? PW_W'(1) : pulse_len;
    gap_ld_c   = (gap_len == '0) ? PW_W'(1) : gap_len;
  end

  // FIFO occupancy: a push while full is accepted only if a pop frees a slot the same cycle.
  always_comb begin
    rd_dir_c  = fifo_mem[rd_ptr];
    full_c    = (count == (DEPTH_W+1)'(DEPTH));
    push_c    = step_in && (!full_c || pop_c);
    drop_c    = step_in && !push_c;
    count_nxt = count;
    if (push_c && !pop_c) begin
      count_nxt = count + (DEPTH_W+1)'(1);
    end else if (!push_c && pop_c) begin
      count_nxt = count - (DEPTH_W+1)'(1);
    end
  end

  // Next-state logic; phase counters latch the timing inputs on phase entry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dir_nxt   = dir_q;
    step_nxt  = step_q;
    pop_c     = 1'b0;
    rise_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && (count != '0)) begin
          pop_c   = 1'b1;
          dir_nxt = rd_dir_c;
          if ((rd_dir_c == dir_q) || (dir_setup == '0)) begin
            state_nxt = ST_HIGH;
            cnt_nxt   = pulse_ld_c;
            step_nxt  = 1'b1;
            rise_c    = 1'b1;
          end else begin
            state_nxt = ST_SETUP;
            cnt_nxt   = dir_setup;
          end
        end
      end
      ST_SETUP: begin
        if (cnt <= PW_W'(1)) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = pulse_ld_c;
          step_nxt  = 1'b1;
          rise_c    = 1'b1;
        end else begin
          cnt_nxt = cnt - PW_W'(1);
        end
      end
      ST_HIGH: begin
        if (cnt <= PW_W'(1)) begin
          state_nxt = ST_LOW;
          cnt_nxt   = gap_ld_c;
          step_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt - PW_W'(1);
        end
      end
      ST_LOW: begin
        if (cnt <= PW_W'(1)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - PW_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        step_nxt  = 1'b0;
      end
    endcase
  end

  // FSM state and pin registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      dir_q  <= dir_nxt;
      step_q <= step_nxt;
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_mem <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push_c) begin
        fifo_mem[wr_ptr] <= dir_in;
        wr_ptr           <= wr_ptr + DEPTH_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + DEPTH_W'(1);
      end
      count <= count_nxt;
    end
  end

  // Position counter (load beats step), sticky overflow (set beats clear), busy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos      <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (pos_load) begin
        pos <= pos_val;
      end else if (rise_c) begin
        pos <= dir_nxt ? (pos + POS_W'(1)) : (pos - POS_W'(1));
      end
      if (drop_c) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
      busy <= (count_nxt != '0) || (state != ST_IDLE) || (state_nxt != ST_IDLE);
    end
  end

  // Polarity applied after the registers so invert bits act on the pins at once.
  assign step_out = step_q ^ invert_step;
  assign dir_out  = dir_q ^ invert_dir;

endmodule

// File: rtl/step_dir_out.sv
// Multi-axis step/dir output stage: one step_axis_chan per axis plus port slicing.
module step_dir_out
  import step_pkg::*;
#(
  parameter int unsigned AXES    = AXES_DEF,
  parameter int unsigned PW_W    = PW_W_DEF,
  parameter int unsigned DEPTH_W = DEPTH_W_DEF,
  parameter int unsigned POS_W   = POS_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [AXES-1:0]       step_in,
  input  logic [AXES-1:0]       dir_in,
  input  logic [PW_W-1:0]       pulse_len,
  input  logic [PW_W-1:0]       gap_len,
  input  logic [PW_W-1:0]       dir_setup,
  input  logic [AXES-1:0]       invert_step,
  input  logic [AXES-1:0]       invert_dir,
  input  logic [AXES-1:0]       pos_load,
  input  logic [AXES*POS_W-1:0] pos_val,
  input  logic [AXES-1:0]       ovf_clr,
  output logic [AXES-1:0]       step_out,
  output logic [AXES-1:0]       dir_out,
  output logic [AXES*POS_W-1:0] pos,
  output logic [AXES-1:0]       overflow,
  output logic [AXES-1:0]       busy
);

  // One independent channel per axis.
  for (genvar i = 0; i < int'(AXES); i++) begin : g_axis
    step_axis_chan #(
      .PW_W    (PW_W),
      .DEPTH_W (DEPTH_W),
      .POS_W   (POS_W)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .step_in     (step_in[i]),
      .dir_in      (dir_in[i]),
      .pulse_len   (pulse_len),
      .gap_len     (gap_len),
      .dir_setup   (dir_setup),
      .invert_step (invert_step[i]),
      .invert_dir  (invert_dir[i]),
      .pos_load    (pos_load[i]),
      .pos_val     (pos_val[i*POS_W +: POS_W]),
      .ovf_clr     (ovf_clr[i]),
      .step_out    (step_out[i]),
      .dir_out     (dir_out[i]),
      .pos         (pos[i*POS_W +: POS_W]),
      .overflow    (overflow[i]),
      .busy        (busy[i])
    );
  end

endmodule

// File: tb/tb_step_dir_out.sv
// Directed bench for step_dir_out: per-scenario tasks with hand-computed expectations.
module tb_step_dir_out;

  localparam int unsigned AXES  = 4;
  localparam int unsigned PW_W  = 16;
  localparam int unsigned POS_W = 32;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  enable;
  logic [AXES-1:0]       step_in, dir_in, invert_step, invert_dir, pos_load, ovf_clr;
  logic [PW_W-1:0]       pulse_len, gap_len, dir_setup;
  logic [AXES*POS_W-1:0] pos_val;
  logic [AXES-1:0]       step_out, dir_out, overflow, busy;
  logic [AXES*POS_W-1:0] pos;

  int tests = 0;
  int fails = 0;

  step_dir_out dut (
    .clk(clk), .rst(rst), .enable(enable), .step_in(step_in), .dir_in(dir_in),
    .pulse_len(pulse_len), .gap_len(gap_len), .dir_setup(dir_setup),
    .invert_step(invert_step), .invert_dir(invert_dir), .pos_load(pos_load),
    .pos_val(pos_val), .ovf_clr(ovf_clr), .step_out(step_out), .dir_out(dir_out),
    .pos(pos), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle n starts 1 time unit after active edge n.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [POS_W-1:0] pos_of(int ax);
    return pos[ax*POS_W +: POS_W];
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    enable = 1'b1; step_in = '0; dir_in = '0;
    pulse_len = 16'd3; gap_len = 16'd2; dir_setup = 16'd0;
    invert_step = '0; invert_dir = '0; pos_load = '0; pos_val = '0; ovf_clr = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b0;
    invert_step = 4'b1010;
    invert_dir  = 4'b0101;
    #1;
    tests++; if (step_out !== 4'b1010) begin fails++; $display("FAIL reset_step_out got %b want 1010", step_out); end
    tests++; if (dir_out !== 4'b0101) begin fails++; $display("FAIL reset_dir_out got %b want 0101", dir_out); end
    tests++; if (pos !== '0) begin fails++; $display("FAIL reset_pos got %h want 0", pos); end
    tests++; if (overflow !== 4'b0000 || busy !== 4'b0000) begin fails++; $display("FAIL reset_flags ovf %b busy %b want 0000 0000", overflow, busy); end
    do_reset();
  endtask

  task automatic test_single_step();
    logic exp_step;
    do_reset();
    dir_in = 4'b0001; step_in = 4'b0001;
    for (int c = 1; c <= 8; c++) begin
      tick();
      step_in = '0;
      exp_step = (c >= 2) && (c <= 4);
      tests++; if (step_out[0] !== exp_step) begin fails++; $display("FAIL single_step_out c%0d got %b want %b", c, step_out[0], exp_step); end
      if (c == 1) begin
        tests++; if (busy[0] !== 1'b1 || pos_of(0) !== 32'd0) begin fails++; $display("FAIL single_c1 busy %b pos %0d want 1 0", busy[0], pos_of(0)); end
      end
      if (c == 2) begin
        tests++; if (pos_of(0) !== 32'd1) begin fails++; $display("FAIL single_pos got %0d want 1", pos_of(0)); end
      end
      if (c == 7) begin
        tests++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL single_busy_c7 got %b want 1", busy[0]); end
      end
      if (c == 8) begin
        tests++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL single_busy_c8 got %b want 0", busy[0]); end
      end
    end
  endtask

  task automatic test_dir_reversal();
    int rise1, rise2, dir_rise, dir_fall, pos_at7;
    logic prev_step, prev_dir;
    do_reset();
    dir_setup = 16'd5;
    rise1 = -1; rise2 = -1; dir_rise = -1; dir_fall = -1; pos_at7 = -1;
    prev_step = 1'b0; prev_dir = 1'b0;
    step_in = 4'b0001; dir_in = 4'b0001;
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (c == 1) begin step_in[0] = 1'b1; dir_in[0] = 1'b0; end
      else step_in = '0;
      if (step_out[0] && !prev_step) begin
        if (rise1 < 0) rise1 = c; else if (rise2 < 0) rise2 = c;
      end
      if (dir_out[0] && !prev_dir && dir_rise < 0) dir_rise = c;
      if (!dir_out[0] && prev_dir && dir_fall < 0) dir_fall = c;
      if (c == 7) pos_at7 = int'(pos_of(0));
      prev_step = step_out[0];
      prev_dir  = dir_out[0];
    end
    tests++; if (dir_rise !== 2) begin fails++; $display("FAIL rev_dir_rise got %0d want 2", dir_rise); end
    tests++; if (rise1 !== 7) begin fails++; $display("FAIL rev_first_rise got %0d want 7", rise1); end
    tests++; if (pos_at7 !== 1) begin fails++; $display("FAIL rev_pos_c7 got %0d want 1", pos_at7); end
    tests++; if (dir_fall !== 13) begin fails++; $display("FAIL rev_dir_fall got %0d want 13", dir_fall); end
    tests++; if (rise2 !== 18) begin fails++; $display("FAIL rev_second_rise got %0d want 18", rise2); end
    tests++; if (pos_of(0) !== 32'd0) begin fails++; $display("FAIL rev_pos_end got %0d want 0", pos_of(0)); end
  endtask

  task automatic test_overflow();
    int rises;
    logic prev_step;
    do_reset();
    pulse_len = 16'd4; gap_len = 16'd4;
    rises = 0; prev_step = 1'b0;
    dir_in = 4'b0001; step_in = 4'b0001;
    for (int c = 1; c <= 100; c++) begin
      tick();
      step_in[0] = (c <= 9);
      if (c == 9) begin
        tests++; if (overflow !== 4'b0000) begin fails++; $display("FAIL ovf_c9 got %b want 0000", overflow); end
      end
      if (c == 10) begin
        tests++; if (overflow !== 4'b0001) begin fails++; $display("FAIL ovf_c10 got %b want 0001", overflow); end
      end
      if (step_out[0] && !prev_step) rises++;
      prev_step = step_out[0];
    end
    tests++; if (rises !== 9) begin fails++; $display("FAIL ovf_pulses got %0d want 9", rises); end
    tests++; if (pos_of(0) !== 32'd9) begin fails++; $display("FAIL ovf_pos got %0d want 9", pos_of(0)); end
    tests++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL ovf_busy got %b want 0", busy[0]); end
    ovf_clr = 4'b0001;
    tick();
    ovf_clr = '0;
    tests++; if (overflow[0] !== 1'b0) begin fails++; $display("FAIL ovf_clr got %b want 0", overflow[0]); end
  endtask

  task automatic test_enable_gating();
    int rises;
    logic prev_step;
    do_reset();
    rises = 0; prev_step = 1'b0;
    dir_in = 4'b0001; step_in = 4'b0001;
    for (int c = 1; c <= 30; c++) begin
      tick();
      step_in[0] = (c <= 2);
      if (c == 3) enable = 1'b0;
      if (c == 4) begin
        tests++; if (step_out[0] !== 1'b1) begin fails++; $display("FAIL en_pulse_c4 got %b want 1", step_out[0]); end
      end
      if (c == 5) begin
        tests++; if (step_out[0] !== 1'b0) begin fails++; $display("FAIL en_pulse_c5 got %b want 0", step_out[0]); end
      end
      if (step_out[0] && !prev_step) rises++;
      prev_step = step_out[0];
    end
    tests++; if (rises !== 1 || pos_of(0) !== 32'd1) begin fails++; $display("FAIL en_gated rises %0d pos %0d want 1 1", rises, pos_of(0)); end
    tests++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL en_gated_busy got %b want 1", busy[0]); end
    enable = 1'b1;
    rises = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (step_out[0] && !prev_step) rises++;
      prev_step = step_out[0];
    end
    tests++; if (rises !== 2 || pos_of(0) !== 32'd3) begin fails++; $display("FAIL en_resume rises %0d pos %0d want 2 3", rises, pos_of(0)); end
    tests++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL en_resume_busy got %b want 0", busy[0]); end
  endtask

  task automatic test_pos_load();
    do_reset();
    dir_in = 4'b0100; step_in = 4'b0100;
    tick();
    step_in = '0;
    pos_load = 4'b0100;
    pos_val[2*POS_W +: POS_W] = 32'd100;
    tick();
    pos_load = '0;
    tests++; if (step_out[2] !== 1'b1) begin fails++; $display("FAIL load_rise got %b want 1", step_out[2]); end
    tests++; if (pos_of(2) !== 32'd100) begin fails++; $display("FAIL load_priority got %0d want 100", pos_of(2)); end
    for (int c = 0; c < 8; c++) tick();
    tests++; if (pos_of(2) !== 32'd100 || pos_of(0) !== 32'd0) begin fails++; $display("FAIL load_hold pos2 %0d pos0 %0d want 100 0", pos_of(2), pos_of(0)); end
    pos_load = 4'b0100;
    pos_val[2*POS_W +: POS_W] = 32'd0;
    tick();
    pos_load = '0;
    dir_in = 4'b0000; step_in = 4'b0100;
    tick();
    step_in = '0;
    tick();
    tests++; if (pos_of(2) !== 32'hFFFF_FFFF) begin fails++; $display("FAIL pos_wrap got %h want ffffffff", pos_of(2)); end
    tests++; if (dir_out[2] !== 1'b0) begin fails++; $display("FAIL wrap_dir got %b want 0", dir_out[2]); end
  endtask

  task automatic test_async_reset();
    int edges;
    logic prev_q;
    do_reset();
    invert_step = 4'b0001;
    #1;
    tests++; if (step_out[0] !== 1'b1) begin fails++; $display("FAIL inv_idle got %b want 1", step_out[0]); end
    dir_in = 4'b0001; step_in = 4'b0001;
    tick();
    tick();
    step_in = '0;
    tick();
    tests++; if (step_out[0] !== 1'b0) begin fails++; $display("FAIL inv_mid_pulse got %b want 0", step_out[0]); end
    #2;
    rst = 1'b0;
    #1;
    tests++; if (step_out[0] !== 1'b1) begin fails++; $display("FAIL async_step got %b want 1", step_out[0]); end
    tests++; if (pos_of(0) !== 32'd0 || busy !== 4'b0000) begin fails++; $display("FAIL async_state pos %0d busy %b want 0 0000", pos_of(0), busy); end
    tick();
    rst = 1'b1;
    edges = 0; prev_q = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if ((step_out[0] ^ invert_step[0]) && !prev_q) edges++;
      prev_q = step_out[0] ^ invert_step[0];
    end
    tests++; if (edges !== 0 || busy[0] !== 1'b0) begin fails++; $display("FAIL async_flush pulses %0d busy %b want 0 0", edges, busy[0]); end
    invert_dir = 4'b1111;
    #1;
    tests++; if (dir_out !== 4'b1111) begin fails++; $display("FAIL inv_dir got %b want 1111", dir_out); end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_dir_reversal();
    test_overflow();
    test_enable_gating();
    test_pos_load();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired tests %0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
